// File: rtl/risc_v_mem_pkg.sv
// Shared RV32I memory-access encodings for the MEM-stage load/store unit.
package risc_v_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] LSU_IDLE   = 2'b00;
   localparam logic [1:0] LSU_RMW_WR = 2'b01;
   localparam logic [1:0] LSU_RESP   = 2'b10;

   // Unsigned widths exist only for loads, so BU/HU on a store is illegal.
   function automatic logic f3_illegal(input logic [2:0] f3, input logic st);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = st;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merging for sub-word stores.
module lsu_align
   import risc_v_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic [31:0] store_merge,
   output logic        misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [4:0]  w_shamt;

   // Select the addressed byte and half-word lanes of the memory word.
   always_comb begin
      w_shamt = {addr_lo, 3'b000};
      w_byte  = 8'(word >> w_shamt);
      if (addr_lo[1]) begin
         w_half = word[31:16];
      end else begin
         w_half = word[15:0];
      end
   end

   // Extend loads, merge store data into the read word, flag misalignment.
   always_comb begin
      load_ext    = 32'd0;
      store_merge = word;
      misalign    = 1'b0;
      case (funct3)
         F3_B: begin
            load_ext    = {{24{w_byte[7]}}, w_byte};
            store_merge = (word & ~(32'h0000_00FF << w_shamt))
                        | ({24'd0, wdata[7:0]} << w_shamt);
         end
         F3_BU: begin
            load_ext = {24'd0, w_byte};
         end
         F3_H: begin
            load_ext = {{16{w_half[15]}}, w_half};
            misalign = addr_lo[0];
            if (addr_lo[1]) begin
               store_merge = {wdata[15:0], word[15:0]};
            end else begin
               store_merge = {word[31:16], wdata[15:0]};
            end
         end
         F3_HU: begin
            load_ext = {16'd0, w_half};
            misalign = addr_lo[0];
         end
         F3_W: begin
            load_ext    = word;
            store_merge = wdata;
            misalign    = |addr_lo;
         end
         default: begin
            load_ext    = 32'd0;
            store_merge = word;
            misalign    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: word-only memory, sub-word stores done as read-modify-write.
module load_store_unit
   import risc_v_mem_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int MEM_BYTES = 64004
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              stall,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_we,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_mem_a;
   logic [31:0]       r_merge;
   logic [31:0]       r_rdata;
   logic              r_done;
   logic              r_err;

   logic [31:0]       w_load_ext;
   logic [31:0]       w_store_merge;
   logic              w_misalign;
   logic              w_err;
   logic [ADDR_W-1:0] w_req_a;

   lsu_align u_align (
      .funct3      (funct3),
      .addr_lo     (addr[1:0]),
      .word        (mem_rd),
      .wdata       (wdata),
      .load_ext    (w_load_ext),
      .store_merge (w_store_merge),
      .misalign    (w_misalign)
   );

   // Request decode from the live inputs, only meaningful in IDLE.
   always_comb begin
      w_req_a = {addr[ADDR_W-1:2], 2'b00};
      w_err   = w_misalign | (addr >= LIMIT) | f3_illegal(funct3, is_store);
   end

   // Memory-side muxing; RMW write phase uses only the latched address and word.
   always_comb begin
      mem_a  = w_req_a;
      mem_we = 1'b0;
      mem_wd = wdata;
      if (!rst) begin
         mem_we = 1'b0;
      end else if (r_state == LSU_RMW_WR) begin
         mem_a  = r_mem_a;
         mem_we = 1'b1;
         mem_wd = r_merge;
      end else if (r_state == LSU_IDLE) begin
         mem_we = req & is_store & ~w_err & (funct3 == F3_W);
      end else begin
         mem_a = r_mem_a;
      end
   end

   // Access FSM and result registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= LSU_IDLE;
         r_mem_a <= '0;
         r_merge <= 32'd0;
         r_rdata <= 32'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            LSU_IDLE: begin
               r_done <= 1'b0;
               if (req) begin
                  r_mem_a <= w_req_a;
                  if (w_err) begin
                     r_err   <= 1'b1;
                     r_rdata <= 32'd0;
                     r_done  <= 1'b1;
                     r_state <= LSU_RESP;
                  end else if (!is_store) begin
                     r_err   <= 1'b0;
                     r_rdata <= w_load_ext;
                     r_done  <= 1'b1;
                     r_state <= LSU_RESP;
                  end else if (funct3 == F3_W) begin
                     r_err   <= 1'b0;
                     r_rdata <= 32'd0;
                     r_done  <= 1'b1;
                     r_state <= LSU_RESP;
                  end else begin
                     r_merge <= w_store_merge;
                     r_state <= LSU_RMW_WR;
                  end
               end
            end
            LSU_RMW_WR: begin
               r_err   <= 1'b0;
               r_rdata <= 32'd0;
               r_done  <= 1'b1;
               r_state <= LSU_RESP;
            end
            LSU_RESP: begin
               r_done  <= 1'b0;
               r_state <= LSU_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= LSU_IDLE;
            end
         endcase
      end
   end

   assign rdata = r_rdata;
   assign done  = r_done;
   assign err   = r_err;
   assign stall = req & ~r_done;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses vs. a memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        is_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        err;
   logic        stall;
   logic [15:0] mem_a;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem     [0:16383];
   logic [31:0] ref_mem [0:16383];
   logic [2:0]  f3_tab  [0:7];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(16), .MEM_BYTES(64004)) dut (
      .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
      .stall(stall), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_a[15:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_a[15:2]] <= mem_wd;
   end

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference: the architectural effect of one access on a flat word array.
   task automatic model_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, output logic e, output logic [31:0] rd,
                               output int lat, output int n_we, output logic [31:0] new_word);
      int          size;
      int          sh;
      logic        legal;
      logic [31:0] mask;
      logic [31:0] word;
      logic [31:0] v;
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
      size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
      e     = !legal || ((a % size) != 0) || (a >= 32'd64004);
      mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      word  = ref_mem[a[15:2]];
      sh    = 8 * int'(a % 4);
      rd = 32'd0; lat = 1; n_we = 0; new_word = word;
      if (!e) begin
         if (!st) begin
            v = (word >> sh) & mask;
            if (!f3[2] && size < 4 && v > (mask >> 1)) v = v - mask - 32'd1;
            rd = v;
         end else begin
            new_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[a[15:2]] = new_word;
            n_we = 1;
            lat  = (size == 4) ? 1 : 2;
         end
      end
   endtask

   task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input bit scramble,
                             output logic [31:0] got_rd, output logic got_err);
      int          cyc;
      int          we_seen;
      int          lat;
      int          n_we;
      bit          got;
      logic        e;
      logic [31:0] rd;
      logic [31:0] new_word;
      @(posedge clk); #1;
      req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      model_access(st, f3, a, wd, e, rd, lat, n_we, new_word);
      cyc = 0; we_seen = 0; got = 1'b0;
      while (!got && cyc < 6) begin
         @(negedge clk);
         chk_val("stall", 32'(stall), 32'(req && (cyc != lat)));
         if (mem_we) begin
            we_seen++;
            chk_val("mem_a", 32'(mem_a), {16'd0, a[15:2], 2'b00});
            chk_val("mem_wd", mem_wd, new_word);
         end
         if (done) begin
            got = 1'b1;
         end else begin
            @(posedge clk); #1;
            cyc++;
            if (scramble) begin
               addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
               is_store = 1'($urandom); req = 1'($urandom);
            end
         end
      end
      chk_val("latency", 32'(cyc), 32'(lat));
      chk_val("err", 32'(err), 32'(e));
      chk_val("rdata", rdata, rd);
      chk_val("we_count", 32'(we_seen), 32'(n_we));
      chk_val("mem_word", mem[a[15:2]], ref_mem[a[15:2]]);
      got_rd = rdata; got_err = err;
      req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [31:0] rd;
      logic        e;
      logic [31:0] nw;
      logic [31:0] a;
      int          lat;
      int          nwe;

      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      rst = 1'b0; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
      for (int i = 0; i < 16384; i++) begin
         v = $urandom;
         mem[i] <= v;
         ref_mem[i] = v;
      end
      mem[16] <= 32'h8899_AABB;
      ref_mem[16] = 32'h8899_AABB;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_val("rst_rdata", rdata, 32'd0);
      chk_val("rst_done", 32'(done), 32'd0);
      chk_val("rst_err", 32'(err), 32'd0);
      chk_val("rst_stall", 32'(stall), 32'd0);
      chk_val("rst_mem_we", 32'(mem_we), 32'd0);
      rst = 1'b1;

      run_access(1'b0, 3'b000, 32'h41, 32'd0, 1'b0, rd, e);
      chk_val("t1_lb", rd, 32'hFFFF_FFAA);
      run_access(1'b0, 3'b101, 32'h42, 32'd0, 1'b0, rd, e);
      chk_val("t2_lhu", rd, 32'h0000_8899);
      run_access(1'b0, 3'b001, 32'h42, 32'd0, 1'b0, rd, e);
      chk_val("t2_lh", rd, 32'hFFFF_8899);
      run_access(1'b1, 3'b000, 32'h43, 32'h1234_56CC, 1'b0, rd, e);
      chk_val("t3_sb_mem", mem[16], 32'hCC99_AABB);
      run_access(1'b1, 3'b010, 32'h46, 32'hDEAD_BEEF, 1'b0, rd, e);
      chk_val("t4_sw_mis", 32'(e), 32'd1);
      run_access(1'b0, 3'b010, 32'hFA04, 32'd0, 1'b0, rd, e);
      chk_val("t4_lw_oor", 32'(e), 32'd1);
      run_access(1'b0, 3'b010, 32'hFA00, 32'd0, 1'b0, rd, e);
      chk_val("t4_lw_edge", 32'(e), 32'd0);
      run_access(1'b0, 3'b001, 32'h42, 32'd0, 1'b0, rd, e);

      // Reset while the RMW write is pending must drop the write.
      @(posedge clk); #1;
      req = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h40; wdata = 32'h0000_5A5A;
      @(negedge clk);
      chk_val("t5_we_rd", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_val("t5_we_forced", 32'(mem_we), 32'd0);
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_val("t5_done", 32'(done), 32'd0);
      chk_val("t5_err", 32'(err), 32'd0);
      chk_val("t5_rdata", rdata, 32'd0);
      chk_val("t5_mem", mem[16], 32'hCC99_AABB);
      rst = 1'b1;
      run_access(1'b0, 3'b010, 32'h40, 32'd0, 1'b0, rd, e);
      chk_val("t5_idle_lw", rd, 32'hCC99_AABB);

      // Back-to-back LW 0x0 then SW 0x4 with req held.
      @(posedge clk); #1;
      req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0; wdata = 32'd0;
      model_access(1'b0, 3'b010, 32'h0, 32'd0, e, rd, lat, nwe, nw);
      @(negedge clk);
      chk_val("t6_stall_T", 32'(stall), 32'd1);
      chk_val("t6_done_T", 32'(done), 32'd0);
      @(negedge clk);
      chk_val("t6_done_T1", 32'(done), 32'd1);
      chk_val("t6_stall_T1", 32'(stall), 32'd0);
      chk_val("t6_rdata", rdata, rd);
      v = $urandom;
      is_store = 1'b1; addr = 32'h4; wdata = v;
      model_access(1'b1, 3'b010, 32'h4, v, e, rd, lat, nwe, nw);
      @(negedge clk);
      chk_val("t6_stall_T2", 32'(stall), 32'd1);
      chk_val("t6_we_T2", 32'(mem_we), 32'd1);
      chk_val("t6_wd_T2", mem_wd, nw);
      chk_val("t6_done_T2", 32'(done), 32'd0);
      @(negedge clk);
      chk_val("t6_done_T3", 32'(done), 32'd1);
      chk_val("t6_stall_T3", 32'(stall), 32'd0);
      chk_val("t6_err_T3", 32'(err), 32'd0);
      chk_val("t6_mem", mem[1], ref_mem[1]);
      req = 1'b0;

      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 3))
            0, 1:    a = 32'($urandom_range(0, 255));
            2:       a = 32'd64004 - 32'd8 + 32'($urandom_range(0, 15));
            default: a = $urandom;
         endcase
         run_access(1'($urandom), f3_tab[$urandom_range(0, 7)], a, $urandom,
                    ($urandom_range(0, 1) == 1), rd, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
